// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the bit-serial ALU sequencer.
//   alu_op_t     3-bit ALU op code (001 and 111 are unused/illegal)
//   seq_state_t  sequencer FSM states
//   alu_flags_t  {n, z, c, v} result flags
//   is_legal_op  1 when a raw 3-bit code maps to a supported op
//   is_arith_op  1 for ADD/SUB, the only ops where carry/overflow mean anything
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return !((op == 3'b001) || (op == 3'b111));
  endfunction

  function automatic logic is_arith_op(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_seq_slice.sv
// alu_serial_seq_slice: single-bit ALU cell shared by the serial sequencer.
// Ports:
//   a, b  operand bits
//   ci    carry in (only meaningful for ADD/SUB)
//   sel   op code (alu_pkg::alu_op_t)
//   y     result bit
//   co    carry out; forced to 0 for non-arithmetic ops
module alu_serial_seq_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    ci,
  input  alu_op_t sel,
  output logic    y,
  output logic    co
);

  logic b_eff;
  logic sum;

  always_comb begin
    // SUB is A + ~B + 1: invert B here, the +1 comes from the seeded carry.
    b_eff = (sel == OP_SUB) ? ~b : b;
    sum   = a ^ b_eff ^ ci;
    y     = 1'b0;
    co    = 1'b0;
    case (sel)
      OP_PASS_B: y = b;
      OP_ADD,
      OP_SUB: begin
        y  = sum;
        co = (a & b_eff) | (a & ci) | (b_eff & ci);
      end
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: runs WIDTH-bit ALU ops bit-serially (LSB first) through
// one shared 1-bit slice, carrying the carry between bits in a flop.
// Optional build macro: ALU_SEQ_EARLY_TERM_EN -- logic ops (PASS_B/AND/OR/XOR)
// use 4 slices and finish in WIDTH/4+1 cycles; ADD/SUB stay 1 bit/cycle.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low; clears all state
//   start    request, accepted only while ready=1
//   op_sel   op code, latched on accept
//   a_in     operand A, latched on accept
//   b_in     operand B, latched on accept
//   ready    can accept start this cycle (IDLE or DONE)
//   done     1-cycle pulse, result/flags valid
//   err      with done: op_sel was illegal
//   result   result, held from done until the next accept
//   flags    {N,Z,C,V}, held with result
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

`ifdef ALU_SEQ_EARLY_TERM_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             nz_q, nz_d;
  alu_flags_t       flags_q, flags_d;
  logic             err_q, err_d;

  logic [LANES-1:0] lane_y;
  logic [LANES-1:0] lane_co;
  logic             fast;
  logic             last_step;
  logic             step_nz;

  // Operands are shifted right each step, so lane k always sees bit i+k.
  // Only lane 0 takes the real carry; the extra lanes serve logic ops only.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_serial_seq_slice u_slice (
      .a  (a_q[k]),
      .b  (b_q[k]),
      .ci ((k == 0) ? carry_q : 1'b0),
      .sel(op_q),
      .y  (lane_y[k]),
      .co (lane_co[k])
    );
  end

  always_comb begin
    fast = 1'b0;
`ifdef ALU_SEQ_EARLY_TERM_EN
    fast = !is_arith_op(op_q);
`endif
    last_step = fast ? (cnt_q == CNT_W'(WIDTH / 4 - 1))
                     : (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    nz_d    = nz_q;
    flags_d = flags_q;
    err_d   = err_q;
    step_nz = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          cnt_d   = '0;
          res_d   = '0;
          nz_d    = 1'b0;
          flags_d = '0;
          if (is_legal_op(op_sel)) begin
            state_d = RUN;
            a_d     = a_in;
            b_d     = b_in;
            op_d    = alu_op_t'(op_sel);
            carry_d = (op_sel == OP_SUB);
            err_d   = 1'b0;
          end else begin
            // Illegal op short-circuits to DONE without touching the slice.
            state_d = DONE;
            carry_d = 1'b0;
            err_d   = 1'b1;
          end
        end
      end

      RUN: begin
`ifdef ALU_SEQ_EARLY_TERM_EN
        if (fast) begin
          res_d   = {lane_y, res_q[WIDTH-1:4]};
          a_d     = a_q >> 4;
          b_d     = b_q >> 4;
          step_nz = |lane_y;
        end else
`endif
        begin
          res_d   = {lane_y[0], res_q[WIDTH-1:1]};
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          step_nz = lane_y[0];
        end
        carry_d = lane_co[0];
        nz_d    = nz_q | step_nz;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d   = DONE;
          cnt_d     = '0;
          flags_d.n = res_d[WIDTH-1];
          flags_d.z = ~(nz_q | step_nz);
          // carry_q is the carry into the MSB on the final step.
          flags_d.c = is_arith_op(op_q) & lane_co[0];
          flags_d.v = is_arith_op(op_q) & (carry_q ^ lane_co[0]);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_PASS_B;
      res_q   <= '0;
      nz_q    <= 1'b0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      nz_q    <= nz_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign ready  = (state_q != RUN);
  assign done   = (state_q == DONE);
  assign err    = done & err_q;
  assign result = res_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (WIDTH=64) with hand-computed expectations.
module tb_alu_serial_seq;

  localparam int W        = 64;
  localparam int LAT_FULL = W + 1;
`ifdef ALU_SEQ_EARLY_TERM_EN
  localparam int LAT_LOGIC = W / 4 + 1;
`else
  localparam int LAT_LOGIC = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op_sel;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_sel(op_sel),
    .a_in  (a_in),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .err   (err),
    .result(result),
    .flags (flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op from a ready cycle and waits for done; leaves the bench
  // in the done cycle so a follow-up call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_flags,
                        input logic exp_err, input int exp_lat);
    int n;
    check({tag, "_ready"}, ready, 1);
    start  = 1'b1;
    op_sel = op;
    a_in   = a;
    b_in   = b;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, n + 1, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, flags, exp_flags);
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] res_at_done;

    // Reset held with start asserted must not accept anything.
    reset  = 1'b0;
    start  = 1'b1;
    op_sel = 3'b010;
    a_in   = 64'd3;
    b_in   = 64'd4;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_no_accept", ready, 1);
    check("rst_no_done", done, 0);

    // Signed overflow into the MSB.
    run_op("add_ovf", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 4'b1001, 1'b0, LAT_FULL);
    tick();
    check("add_ovf_pulse", done, 0);
    check("add_ovf_hold", result, 64'h8000_0000_0000_0000);

    run_op("sub_eq", 3'b011, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0, LAT_FULL);
    // Issued in the done cycle of the previous op.
    run_op("sub_borrow", 3'b011, 64'd0, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, LAT_FULL);
    run_op("add_cout", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           64'd0, 4'b0110, 1'b0, LAT_FULL);

    run_op("and", 3'b100, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1'b0, LAT_LOGIC);
    run_op("or", 3'b101, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000, 1'b0, LAT_LOGIC);
    run_op("xor", 3'b110, 64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000, 1'b0, LAT_LOGIC);
    run_op("pass_b", 3'b000, 64'hF0F0, 64'hFF00, 64'hFF00, 4'b0000, 1'b0, LAT_LOGIC);
    run_op("xor_zero", 3'b110, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
           64'd0, 4'b0100, 1'b0, LAT_LOGIC);

    tick();
    run_op("ill_111", 3'b111, 64'd9, 64'd9, 64'd0, 4'b0000, 1'b1, 1);
    tick();
    check("ill_111_pulse", done, 0);
    check("ill_111_err_low", err, 0);
    run_op("ill_001", 3'b001, 64'd9, 64'd9, 64'd0, 4'b0000, 1'b1, 1);
    tick();

    // Start pulsed during RUN is dropped.
    start  = 1'b1;
    op_sel = 3'b010;
    a_in   = 64'd100;
    b_in   = 64'd23;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("run_busy", ready, 0);
    start  = 1'b1;
    op_sel = 3'b110;
    a_in   = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in   = 64'd1;
    tick();
    start       = 1'b0;
    dcnt        = 0;
    res_at_done = '0;
    for (int i = 0; i < 150; i++) begin
      if (done) begin
        dcnt++;
        res_at_done = result;
      end
      tick();
    end
    check("run_start_single_done", dcnt, 1);
    check("run_start_result", res_at_done, 64'd123);

    // Reset mid-RUN aborts the op.
    start  = 1'b1;
    op_sel = 3'b010;
    a_in   = 64'd1000;
    b_in   = 64'd1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort_no_done", dcnt, 0);
    run_op("post_abort_add", 3'b010, 64'd3, 64'd4, 64'd7, 4'b0000, 1'b0, LAT_FULL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
